// File: rtl/sccomp_reg_viewer.sv
// Register viewer for sccomp: selects a register over reg_sel, captures reg_data, and
// scans it onto an 8-digit 7-segment display. Optional build macro: REG_VIEWER_INDEX_EN.
module sccomp_reg_viewer #(
    parameter int CLK_DIV      = 100000,
    parameter int DWELL_FRAMES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode_auto,
    input  logic [4:0]  sw_sel,
    input  logic [31:0] reg_data,
    output logic [4:0]  reg_sel,
    output logic [7:0]  seg_an,
    output logic [7:0]  seg_cat
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [FW-1:0] FRAME_MAX = FW'(DWELL_FRAMES - 1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SETTLE = 2'd1,
        LATCH  = 2'd2
    } state_t;

    logic [PW-1:0] presc;
    logic [2:0]    digit;
    logic [FW-1:0] frame_cnt;
    logic [31:0]   shadow;
    state_t        state_q;
    state_t        state_d;
    logic          tick;
    logic          frame_bnd;
    logic          sel_load;
    logic          capture;
    logic [3:0]    nibble;
    logic          dp_on;

    assign tick      = (presc == PRESC_MAX);
    assign frame_bnd = tick && (digit == 3'd7);

    // Active-low segment pattern {g,f,e,d,c,b,a} for a hex nibble.
    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0:    seg7 = 7'h40;
            4'h1:    seg7 = 7'h79;
            4'h2:    seg7 = 7'h24;
            4'h3:    seg7 = 7'h30;
            4'h4:    seg7 = 7'h19;
            4'h5:    seg7 = 7'h12;
            4'h6:    seg7 = 7'h02;
            4'h7:    seg7 = 7'h78;
            4'h8:    seg7 = 7'h00;
            4'h9:    seg7 = 7'h10;
            4'hA:    seg7 = 7'h08;
            4'hB:    seg7 = 7'h03;
            4'hC:    seg7 = 7'h46;
            4'hD:    seg7 = 7'h21;
            4'hE:    seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            digit <= 3'd0;
        end else if (tick) begin
            presc <= '0;
            digit <= digit + 3'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (frame_bnd) begin
            frame_cnt <= (frame_cnt == FRAME_MAX) ? '0 : frame_cnt + FW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        sel_load = 1'b0;
        capture  = 1'b0;
        case (state_q)
            RUN: begin
                if (frame_bnd) begin
                    state_d  = SETTLE;
                    sel_load = 1'b1;
                end
            end
            SETTLE: state_d = LATCH;
            LATCH: begin
                capture = 1'b1;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Boundaries that land in SETTLE/LATCH (tiny CLK_DIV) never reach sel_load.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_sel <= 5'd0;
        end else if (sel_load) begin
            if (!mode_auto) begin
                reg_sel <= sw_sel;
            end else if (frame_cnt == FRAME_MAX) begin
                reg_sel <= reg_sel + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= 32'd0;
        end else if (capture) begin
            shadow <= reg_data;
        end
    end

`ifdef REG_VIEWER_INDEX_EN
    logic [4:0] shown_sel;

    // Index latched alongside shadow so the label always matches the value shown.
    always_ff @(posedge clk) begin
        if (rst) begin
            shown_sel <= 5'd0;
        end else if (capture) begin
            shown_sel <= reg_sel;
        end
    end

    always_comb begin
        nibble = shadow[{digit, 2'b00} +: 4];
        dp_on  = 1'b0;
        case (digit)
            3'd7: nibble = {3'b000, shown_sel[4]};
            3'd6: begin
                nibble = shown_sel[3:0];
                dp_on  = 1'b1;
            end
            default: ;
        endcase
    end
`else
    always_comb begin
        nibble = shadow[{digit, 2'b00} +: 4];
        dp_on  = 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_an  <= 8'hFF;
            seg_cat <= 8'hFF;
        end else begin
            seg_an  <= ~(8'h01 << digit);
            seg_cat <= {~dp_on, seg7(nibble)};
        end
    end

endmodule
